// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Bus between software/sequencer control and the duty ramp controller.
// The master drives commands and PWM period ticks; the slave returns duty and status.
interface pwm_duty_ramp_ctrl_if #(
  parameter int DUTY_W = 32
);
  logic              Start;
  logic              Abort;
  logic [DUTY_W-1:0] TargetDuty;
  logic [DUTY_W-1:0] Step;
  logic              PeriodEnd;
  logic              IrqClear;
  logic [DUTY_W-1:0] DutyCycle;
  logic              Busy;
  logic              Done;
  logic              Irq;

  modport master (
    output Start, Abort, TargetDuty, Step, PeriodEnd, IrqClear,
    input  DutyCycle, Busy, Done, Irq
  );

  modport slave (
    input  Start, Abort, TargetDuty, Step, PeriodEnd, IrqClear,
    output DutyCycle, Busy, Done, Irq
  );
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Ramps the PWM DutyCycle toward a clamped target by one step per PWM period,
// raising a one-cycle Done and a sticky Irq when the target is reached.
module pwm_duty_ramp_ctrl #(
  parameter int DUTY_W    = 32,
  parameter int MAX_DUTY  = 1000000,
  parameter int INIT_DUTY = 0
) (
  input logic               Clk,
  input logic               Reset,
  pwm_duty_ramp_ctrl_if.slave bus
);

  localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(INIT_DUTY);

  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

  state_t            state, state_nx;
  logic [DUTY_W-1:0] duty, tgt, stp;
  logic              irq;
  logic [DUTY_W-1:0] start_tgt, step_val;
  logic              start_done, take_step;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] t);
    return (t > MAX_V) ? MAX_V : t;
  endfunction

  // Distance-based comparison: never forms cur+stp when it could overflow or overshoot.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] dst,
                                                    input logic [DUTY_W-1:0] inc);
    if (cur < dst)
      return ((dst - cur) <= inc) ? dst : cur + inc;
    else if (cur > dst)
      return ((cur - dst) <= inc) ? dst : cur - inc;
    else
      return cur;
  endfunction

  assign start_tgt  = clamp_duty(bus.TargetDuty);
  assign start_done = (bus.Step == '0) || (start_tgt == duty);
  assign step_val   = step_toward(duty, tgt, stp);
  assign take_step  = (state == RAMP) && !bus.Start && !bus.Abort && bus.PeriodEnd;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Start is honoured in every state and beats both Abort and PeriodEnd.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      DONE:    state_nx = IDLE;
      RAMP: begin
        if (bus.Abort)        state_nx = IDLE;
        else if (take_step && step_val == tgt) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.Start) state_nx = start_done ? DONE : RAMP;
  end

  always_comb begin
    bus.DutyCycle = duty;
    bus.Busy      = (state == RAMP);
    bus.Done      = (state == DONE);
    bus.Irq       = irq;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      duty <= INIT_V;
      tgt  <= INIT_V;
      stp  <= '0;
    end else if (bus.Start) begin
      tgt <= start_tgt;
      stp <= bus.Step;
      if (start_done) duty <= start_tgt;
    end else if (take_step) begin
      duty <= step_val;
    end
  end

  // Irq is set on entry to DONE and held through it, so a clear during Done loses.
  always_ff @(posedge Clk) begin
    if (Reset)                                irq <= 1'b0;
    else if (state_nx == DONE || state == DONE) irq <= 1'b1;
    else if (bus.IrqClear)                    irq <= 1'b0;
  end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
Name: pwm_duty_ramp_ctrl

Overview:
- Sequencer that drives the 32-bit DutyCycle input of the PWM controller.
- Ramps the duty from its current value toward a software-written target in fixed steps, one step per PWM period.
- Uses the PWM controller's period-end interrupt pulse as the step tick.
- Raises a sticky completion interrupt toward the MIPSfpga interrupt input when the target is reached.

Parameters:
- DUTY_W, 32, width of the duty, target and step values.
- MAX_DUTY, 1000000, upper clamp applied to any target.
- INIT_DUTY, 0, DutyCycle value after reset.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle pulse: latch TargetDuty/Step and begin ramp.
- Abort  in  1  one-cycle pulse: stop the ramp and hold the current duty.
- TargetDuty  in  DUTY_W  requested final duty, sampled on Start.
- Step  in  DUTY_W  increment per period, sampled on Start.
- PeriodEnd  in  1  one-cycle pulse from the PWM controller at the end of each PWM period.
- IrqClear  in  1  one-cycle pulse: clear Irq.
- DutyCycle  out  DUTY_W  registered duty to the PWM controller.
- Busy  out  1  high while state is RAMP.
- Done  out  1  one-cycle pulse when the target is reached.
- Irq  out  1  sticky completion interrupt.

Behaviour:
- Reset, when Reset=1 at a rising edge:
  - DutyCycle=INIT_DUTY, Busy=0, Done=0, Irq=0, state=IDLE.
  - Latched target=INIT_DUTY, latched step=0.
  - Reset overrides all other inputs, including a ramp in progress.
- States: IDLE, RAMP, DONE.
- IDLE:
  - Start -> latch tgt=min(TargetDuty,MAX_DUTY) and stp=Step.
  - If stp==0 or tgt==DutyCycle, go to DONE next cycle. DutyCycle is loaded with tgt in that same edge.
  - Otherwise go to RAMP.
  - Busy rises the cycle after Start.
- RAMP, on each PeriodEnd:
  - If DutyCycle<tgt: DutyCycle <= (tgt-DutyCycle <= stp) ? tgt : DutyCycle+stp.
  - If DutyCycle>tgt: DutyCycle <= (DutyCycle-tgt <= stp) ? tgt : DutyCycle-stp.
  - Compare using the difference, never the sum, so there is no overflow and no overshoot.
  - DutyCycle changes the cycle after PeriodEnd and only at PeriodEnd; it is constant within a PWM period.
  - When the updated value equals tgt, go to DONE.
- DONE (one cycle):
  - Done=1, Irq set, Busy=0.
  - Return to IDLE next cycle.
- Start during RAMP (retarget):
  - Re-latch tgt and stp; continue from the current DutyCycle.
  - Same tgt==DutyCycle / stp==0 rules as in IDLE.
- Start during DONE: handled as Start in IDLE.
- Start and PeriodEnd in the same cycle: Start wins, no step is taken that cycle.
- Abort:
  - In RAMP: go to IDLE the next cycle, keep DutyCycle, no Done, Irq unchanged.
  - In IDLE/DONE: ignored.
  - Abort and Start in the same cycle: Start wins.
- Irq:
  - Set in DONE, cleared by IrqClear.
  - Set and clear in the same cycle: set wins.
- PeriodEnd in IDLE or DONE: ignored.

Test Plan:
- Reset with INIT_DUTY=0: hold Reset=1 for 2 clocks -> DutyCycle=0, Busy=0, Irq=0. Assert Reset mid-ramp at DutyCycle=300000 -> next edge DutyCycle=0, state IDLE, no Done.
- Up ramp: Start with TargetDuty=900000, Step=300000, then 3 PeriodEnd pulses -> DutyCycle 300000, 600000, 900000; Done pulses once after the third; Irq=1; Busy low.
- Saturating down ramp: from 900000, Start with TargetDuty=100000, Step=300000 -> 600000, 300000, 100000 (last step clamped); exactly 3 PeriodEnd; no underflow.
- Clamp and zero step: Start with TargetDuty=990999, Step=0 -> DutyCycle=990999 next cycle with Done. Start with TargetDuty=2000000 -> tgt clamped to 1000000.
- Collisions:
  - Start with PeriodEnd in the same cycle -> no step taken.
  - Abort at DutyCycle=600000 -> holds 600000, Busy=0, no Done.
  - IrqClear together with Done -> Irq stays 1; a later IrqClear -> Irq=0.
- Retarget: ramping 0 -> 900000 with Step=300000; at 300000, Start with TargetDuty=0, Step=100000 -> 200000, 100000, 0, then Done.
